// File: rtl/branch_resolver.sv
// Execute-side branch resolver: keeps fetch predictions in an in-order queue, checks them
// against execute outcomes, and on a mispredict flushes and redirects fetch, then holds it off.
module branch_resolver #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pred_valid,
  input  logic                 pred_taken,
  input  logic [31:0]          pred_pc,
  input  logic [31:0]          pred_target,
  output logic                 pred_ready,
  input  logic                 res_valid,
  input  logic                 res_taken,
  input  logic [31:0]          res_target,
  output logic                 flush,
  output logic [31:0]          redirect_pc,
  output logic                 upd_valid,
  output logic                 upd_taken,
  output logic                 q_empty,
  output logic                 res_err,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HOLD} state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    if (en && (v != '1)) return v + CNT_WIDTH'(1);
    return v;
  endfunction

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;

  logic [31:0]       q_pc     [DEPTH];
  logic [31:0]       q_target [DEPTH];
  logic [DEPTH-1:0]  q_taken;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [OCC_W-1:0]  count;

  logic              head_taken;
  logic [31:0]       head_pc, head_target;
  logic              push, push_eff, res_fire, pop, err_evt, mispred;

  assign head_taken  = q_taken[rd_ptr];
  assign head_pc     = q_pc[rd_ptr];
  assign head_target = q_target[rd_ptr];

  assign q_empty    = (count == '0);
  assign pred_ready = (state == S_RUN) && (count < OCC_W'(DEPTH));
  assign flush      = (state == S_FLUSH);

  assign push     = pred_valid && pred_ready;
  assign res_fire = (state == S_RUN) && res_valid;
  assign pop      = res_fire && !q_empty;
  assign err_evt  = res_fire && q_empty;
  assign mispred  = pop && ((head_taken != res_taken) ||
                            (head_taken && res_taken && (head_target != res_target)));
  // A push racing a mispredicting resolve is wrong-path and never lands.
  assign push_eff = push && !mispred;

  // Stage p0 -> p1: queue payload storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (push_eff) begin
      q_pc[wr_ptr]     <= pred_pc;
      q_target[wr_ptr] <= pred_target;
      q_taken[wr_ptr]  <= pred_taken;
    end
  end

  // Stage p0 -> p1: queue control, training pulse, redirect and statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      upd_valid   <= 1'b0;
      upd_taken   <= 1'b0;
      res_err     <= 1'b0;
      redirect_pc <= '0;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      upd_valid   <= pop;
      if (pop) upd_taken <= res_taken;
      if (err_evt) res_err <= 1'b1;
      branch_cnt  <= sat_inc(branch_cnt, pop);
      mispred_cnt <= sat_inc(mispred_cnt, mispred);
      if (mispred) begin
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        count       <= '0;
        redirect_pc <= res_taken ? res_target : head_pc + 32'd4;
      end else begin
        if (push_eff) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + OCC_W'(push_eff) - OCC_W'(pop);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_RUN;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      S_RUN: begin
        if (mispred) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        state_nxt = S_HOLD;
        hold_nxt  = HOLD_W'(HOLD_CYCLES);
      end
      S_HOLD: begin
        hold_nxt = hold_cnt - HOLD_W'(1);
        if (hold_cnt <= HOLD_W'(1)) state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver (DEPTH=4, HOLD_CYCLES=2, CNT_WIDTH=4 so saturation is reachable).
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        reset;
  logic        pred_valid, pred_taken, pred_ready;
  logic [31:0] pred_pc, pred_target;
  logic        res_valid, res_taken;
  logic [31:0] res_target;
  logic        flush, upd_valid, upd_taken, q_empty, res_err;
  logic [31:0] redirect_pc;
  logic [3:0]  branch_cnt, mispred_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_resolver #(.DEPTH(4), .HOLD_CYCLES(2), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc),
    .pred_target(pred_target), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .flush(flush), .redirect_pc(redirect_pc), .upd_valid(upd_valid), .upd_taken(upd_taken),
    .q_empty(q_empty), .res_err(res_err), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pred_valid = 0; pred_taken = 0; pred_pc = '0; pred_target = '0;
    res_valid = 0; res_taken = 0; res_target = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    reset = 0;
    tick();
    tick();
    reset = 1;
  endtask

  task automatic drive_push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    pred_valid = 1; pred_pc = pc; pred_taken = tk; pred_target = tg;
  endtask

  task automatic drive_res(input logic tk, input logic [31:0] tg);
    res_valid = 1; res_taken = tk; res_target = tg;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    #13;
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush got %b exp 0", flush); end
    n_tests++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL rst_redirect got %h exp 0", redirect_pc); end
    n_tests++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_upd_valid got %b exp 0", upd_valid); end
    n_tests++; if (upd_taken !== 1'b0) begin n_fail++; $display("FAIL rst_upd_taken got %b exp 0", upd_taken); end
    n_tests++; if (res_err !== 1'b0) begin n_fail++; $display("FAIL rst_res_err got %b exp 0", res_err); end
    n_tests++; if (branch_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_branch_cnt got %0d exp 0", branch_cnt); end
    n_tests++; if (mispred_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_mispred_cnt got %0d exp 0", mispred_cnt); end
    n_tests++; if (q_empty !== 1'b1) begin n_fail++; $display("FAIL rst_q_empty got %b exp 1", q_empty); end
    reset = 1;
    tick();
    n_tests++; if (pred_ready !== 1'b1) begin n_fail++; $display("FAIL rst_pred_ready got %b exp 1", pred_ready); end
  endtask

  task automatic test_correct();
    reset_dut();
    drive_push(32'h100, 1, 32'h180);
    tick();
    idle_inputs();
    n_tests++; if (q_empty !== 1'b0) begin n_fail++; $display("FAIL ok_q_nonempty got %b exp 0", q_empty); end
    drive_res(1, 32'h180);
    tick();
    idle_inputs();
    n_tests++; if (upd_valid !== 1'b1) begin n_fail++; $display("FAIL ok_upd_valid got %b exp 1", upd_valid); end
    n_tests++; if (upd_taken !== 1'b1) begin n_fail++; $display("FAIL ok_upd_taken got %b exp 1", upd_taken); end
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL ok_flush got %b exp 0", flush); end
    n_tests++; if (branch_cnt !== 4'd1) begin n_fail++; $display("FAIL ok_branch_cnt got %0d exp 1", branch_cnt); end
    n_tests++; if (mispred_cnt !== 4'd0) begin n_fail++; $display("FAIL ok_mispred_cnt got %0d exp 0", mispred_cnt); end
    n_tests++; if (q_empty !== 1'b1) begin n_fail++; $display("FAIL ok_q_empty got %b exp 1", q_empty); end
    tick();
    n_tests++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL ok_upd_pulse got %b exp 0", upd_valid); end
  endtask

  task automatic test_dir_mispred();
    reset_dut();
    drive_push(32'h200, 1, 32'h240);
    tick();
    drive_push(32'h204, 0, 32'h260);
    tick();
    idle_inputs();
    drive_res(0, 32'h0);
    tick();
    // FLUSH cycle: keep both inputs active to show they are ignored
    drive_res(0, 32'h0);
    drive_push(32'h700, 0, 32'h0);
    n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL dir_flush got %b exp 1", flush); end
    n_tests++; if (redirect_pc !== 32'h204) begin n_fail++; $display("FAIL dir_redirect got %h exp 204", redirect_pc); end
    n_tests++; if (q_empty !== 1'b1) begin n_fail++; $display("FAIL dir_q_empty got %b exp 1", q_empty); end
    n_tests++; if (pred_ready !== 1'b0) begin n_fail++; $display("FAIL dir_ready_c0 got %b exp 0", pred_ready); end
    n_tests++; if (mispred_cnt !== 4'd1) begin n_fail++; $display("FAIL dir_mispred_cnt got %0d exp 1", mispred_cnt); end
    n_tests++; if ({upd_valid, upd_taken} !== 2'b10) begin n_fail++; $display("FAIL dir_upd got %b exp 10", {upd_valid, upd_taken}); end
    tick();
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL dir_flush_drop got %b exp 0", flush); end
    n_tests++; if (pred_ready !== 1'b0) begin n_fail++; $display("FAIL dir_ready_c1 got %b exp 0", pred_ready); end
    n_tests++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL dir_upd_ignored got %b exp 0", upd_valid); end
    n_tests++; if (res_err !== 1'b0) begin n_fail++; $display("FAIL dir_res_ignored got %b exp 0", res_err); end
    tick();
    n_tests++; if (pred_ready !== 1'b0) begin n_fail++; $display("FAIL dir_ready_c2 got %b exp 0", pred_ready); end
    n_tests++; if (res_err !== 1'b0) begin n_fail++; $display("FAIL dir_res_ignored2 got %b exp 0", res_err); end
    tick();
    res_valid = 0;
    n_tests++; if (pred_ready !== 1'b1) begin n_fail++; $display("FAIL dir_ready_c3 got %b exp 1", pred_ready); end
    n_tests++; if (q_empty !== 1'b1) begin n_fail++; $display("FAIL dir_no_early_push got %b exp 1", q_empty); end
    n_tests++; if (redirect_pc !== 32'h204) begin n_fail++; $display("FAIL dir_redirect_hold got %h exp 204", redirect_pc); end
    tick();
    idle_inputs();
    n_tests++; if (q_empty !== 1'b0) begin n_fail++; $display("FAIL dir_push_after_hold got %b exp 0", q_empty); end
  endtask

  task automatic test_target_mispred();
    reset_dut();
    drive_push(32'h300, 1, 32'h340);
    tick();
    idle_inputs();
    drive_res(1, 32'h380);
    tick();
    idle_inputs();
    n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL tgt_flush got %b exp 1", flush); end
    n_tests++; if (redirect_pc !== 32'h380) begin n_fail++; $display("FAIL tgt_redirect got %h exp 380", redirect_pc); end
    n_tests++; if (upd_taken !== 1'b1) begin n_fail++; $display("FAIL tgt_upd_taken got %b exp 1", upd_taken); end
    n_tests++; if (mispred_cnt !== 4'd1) begin n_fail++; $display("FAIL tgt_mispred_cnt got %0d exp 1", mispred_cnt); end
  endtask

  task automatic test_push_vs_mispred();
    reset_dut();
    drive_push(32'h400, 0, 32'h0);
    tick();
    drive_push(32'h404, 1, 32'h500);
    drive_res(1, 32'h480);
    tick();
    idle_inputs();
    n_tests++; if (q_empty !== 1'b1) begin n_fail++; $display("FAIL race_push_dropped got %b exp 1", q_empty); end
    n_tests++; if (redirect_pc !== 32'h480) begin n_fail++; $display("FAIL race_redirect got %h exp 480", redirect_pc); end
  endtask

  task automatic test_full_wrap();
    logic [9:0] tk_pat;
    int mq[$];
    int h;
    tk_pat = 10'b1011001101;
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      drive_push(32'h1000 + 4 * i, tk_pat[i], 32'h2000 + 16 * i);
      mq.push_back(i);
      tick();
    end
    idle_inputs();
    n_tests++; if (pred_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b exp 0", pred_ready); end
    drive_push(32'hDEAD0, ~tk_pat[1], 32'h0);
    h = mq.pop_front();
    drive_res(tk_pat[h], 32'h2000 + 16 * h);
    tick();
    idle_inputs();
    n_tests++; if ({upd_valid, upd_taken} !== {1'b1, tk_pat[0]}) begin n_fail++; $display("FAIL full_upd got %b exp %b", {upd_valid, upd_taken}, {1'b1, tk_pat[0]}); end
    n_tests++; if (pred_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop got %b exp 1", pred_ready); end
    for (int i = 4; i < 10; i++) begin
      drive_push(32'h1000 + 4 * i, tk_pat[i], 32'h2000 + 16 * i);
      h = mq.pop_front();
      drive_res(tk_pat[h], 32'h2000 + 16 * h);
      mq.push_back(i);
      tick();
      n_tests++; if ({flush, upd_valid, upd_taken} !== {2'b01, tk_pat[h]}) begin n_fail++; $display("FAIL wrap_order entry %0d got %b exp %b", h, {flush, upd_valid, upd_taken}, {2'b01, tk_pat[h]}); end
    end
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      h = mq.pop_front();
      drive_res(tk_pat[h], 32'h2000 + 16 * h);
      tick();
      n_tests++; if ({flush, upd_valid, upd_taken} !== {2'b01, tk_pat[h]}) begin n_fail++; $display("FAIL drain_order entry %0d got %b exp %b", h, {flush, upd_valid, upd_taken}, {2'b01, tk_pat[h]}); end
    end
    idle_inputs();
    n_tests++; if (q_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_q_empty got %b exp 1", q_empty); end
    n_tests++; if (branch_cnt !== 4'd10) begin n_fail++; $display("FAIL wrap_branch_cnt got %0d exp 10", branch_cnt); end
    n_tests++; if (mispred_cnt !== 4'd0) begin n_fail++; $display("FAIL wrap_mispred_cnt got %0d exp 0", mispred_cnt); end
  endtask

  task automatic test_err();
    reset_dut();
    drive_res(1, 32'h0);
    tick();
    idle_inputs();
    n_tests++; if (res_err !== 1'b1) begin n_fail++; $display("FAIL err_set got %b exp 1", res_err); end
    n_tests++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL err_no_upd got %b exp 0", upd_valid); end
    n_tests++; if (branch_cnt !== 4'd0) begin n_fail++; $display("FAIL err_branch_cnt got %0d exp 0", branch_cnt); end
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL err_flush got %b exp 0", flush); end
    drive_push(32'h800, 0, 32'h0);
    tick();
    idle_inputs();
    drive_res(0, 32'h0);
    tick();
    idle_inputs();
    n_tests++; if (res_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", res_err); end
  endtask

  task automatic test_saturation();
    reset_dut();
    drive_push(32'h500, 0, 32'h0);
    tick();
    for (int k = 0; k < 17; k++) begin
      drive_push(32'h504 + 4 * k, 0, 32'h0);
      drive_res(0, 32'h0);
      tick();
      if (k == 13) begin
        n_tests++; if (branch_cnt !== 4'd14) begin n_fail++; $display("FAIL sat_pre got %0d exp 14", branch_cnt); end
      end
    end
    idle_inputs();
    n_tests++; if (branch_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_branch_cnt got %0d exp 15", branch_cnt); end
    n_tests++; if (mispred_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_mispred_cnt got %0d exp 0", mispred_cnt); end
  endtask

  task automatic test_reset_mid_recovery();
    reset_dut();
    drive_res(0, 32'h0);
    tick();
    idle_inputs();
    drive_push(32'h600, 1, 32'h640);
    tick();
    idle_inputs();
    drive_res(0, 32'h0);
    tick();
    idle_inputs();
    tick();
    n_tests++; if (pred_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_hold got %b exp 0", pred_ready); end
    #2 reset = 0;
    #1;
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL mid_flush got %b exp 0", flush); end
    n_tests++; if (res_err !== 1'b0) begin n_fail++; $display("FAIL mid_res_err got %b exp 0", res_err); end
    n_tests++; if ({branch_cnt, mispred_cnt} !== 8'h00) begin n_fail++; $display("FAIL mid_counters got %h exp 00", {branch_cnt, mispred_cnt}); end
    n_tests++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL mid_redirect got %h exp 0", redirect_pc); end
    n_tests++; if (q_empty !== 1'b1) begin n_fail++; $display("FAIL mid_q_empty got %b exp 1", q_empty); end
    reset = 1;
    tick();
    n_tests++; if (pred_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got %b exp 1", pred_ready); end
    // Reset landing in the FLUSH cycle must drop flush without a clock edge
    drive_push(32'h900, 1, 32'h940);
    tick();
    idle_inputs();
    drive_res(0, 32'h0);
    tick();
    idle_inputs();
    n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL async_pre got %b exp 1", flush); end
    #1 reset = 0;
    #1;
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL async_flush_drop got %b exp 0", flush); end
    reset = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_correct();
    test_dir_mispred();
    test_target_mispred();
    test_push_vs_mispred();
    test_full_wrap();
    test_err();
    test_saturation();
    test_reset_mid_recovery();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Execute-side counterpart of the fetch-stage branch predictor.
- Fetch pushes each predicted branch (PC, predicted direction, predicted target) into an in-order queue.
- Execute resolves the oldest branch with its actual outcome. The block compares prediction and outcome, and on a mispredict it raises a flush with a redirect PC.
- It returns a per-branch training update to the predictor and keeps branch and mispredict statistics.

Parameters:
DEPTH, 4, prediction-queue entries (power of 2, >=2)
HOLD_CYCLES, 2, cycles pushes/resolves are blocked after a flush (>=1)
CNT_WIDTH, 16, width of statistics counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
pred_valid  in  1  fetch presents a predicted branch
pred_taken  in  1  predicted direction (predictor BP output)
pred_pc  in  32  PC of the branch
pred_target  in  32  predicted taken target
pred_ready  out  1  queue can accept a push this cycle
res_valid  in  1  execute resolves the oldest queued branch
res_taken  in  1  actual direction
res_target  in  32  actual taken target
flush  out  1  one-cycle pulse: kill younger instructions
redirect_pc  out  32  fetch restart PC, valid while flush=1
upd_valid  out  1  one-cycle training pulse to predictor (drives BranchB)
upd_taken  out  1  actual direction for training (drives ZeroB)
q_empty  out  1  queue holds no entries
res_err  out  1  sticky: resolve seen with empty queue
branch_cnt  out  CNT_WIDTH  resolved branches, saturating
mispred_cnt  out  CNT_WIDTH  mispredicted branches, saturating

Behaviour:
- Reset (reset=0, asynchronous):
  - queue cleared; state RUN; hold counter 0.
  - flush, redirect_pc, upd_valid, upd_taken, res_err, branch_cnt, mispred_cnt all 0.
  - q_empty=1; pred_ready=1 once reset is released.
- Queue:
  - circular FIFO with read/write pointers of log2(DEPTH) bits and an occupancy count of 0..DEPTH; pointers wrap modulo DEPTH.
  - pred_ready = (state==RUN) && (count<DEPTH). There is no same-cycle pop bypass, so a full queue refuses a push even while a resolve pops.
  - push when pred_valid && pred_ready.
- Resolve (state RUN, res_valid=1):
  - Queue empty: no pop, res_err<=1 (sticky until reset), no update, counters unchanged.
  - Otherwise pop the head entry E.
  - mispredict = (E.taken != res_taken) || (E.taken && res_taken && E.target != res_target).
  - Next cycle: upd_valid=1, upd_taken=res_taken for every resolve, mispredicted or not.
  - branch_cnt increments; mispred_cnt increments if mispredict. Both hold at all-ones.
- Mispredict recovery state machine (RUN -> FLUSH -> HOLD -> RUN):
  - RUN: normal push and resolve. On a mispredicting resolve, go to FLUSH.
  - FLUSH: exactly one cycle, the cycle after the resolve.
    - flush=1; redirect_pc = res_taken ? res_target : E.pc+4, registered at the resolve edge.
    - All remaining entries are discarded as wrong-path (count<=0, pointers reset). A push in the resolving cycle is also discarded.
    - pred_ready=0; res_valid ignored. Go to HOLD with hold counter = HOLD_CYCLES.
  - HOLD: pred_ready=0; res_valid ignored. The counter decrements each cycle; at 1, go to RUN.
  - flush is 0 in every state except FLUSH. redirect_pc holds its last value otherwise.
- Latency:
  - resolve -> upd_valid/flush: 1 cycle.
  - mispredicting resolve -> next accepted push: 2+HOLD_CYCLES cycles.
- Simultaneous events:
  - Push and correct resolve in one cycle: both take effect, count unchanged.
  - Push and mispredicting resolve: push dropped.
- q_empty = (count==0), combinational from registered state.
- reset asserted mid-recovery: immediate return to reset state, flush drops asynchronously.

Test Plan:
- Correct prediction:
  - Stimulus: push {pc=0x100, taken=1, target=0x180}; resolve taken=1, target=0x180.
  - Response: upd_valid=1, upd_taken=1 next cycle; flush=0; branch_cnt=1, mispred_cnt=0; q_empty=1.
- Direction mispredict, not-taken actual:
  - Stimulus: push {0x200, taken=1, 0x240}, then push {0x204, 0, 0x260}; resolve res_taken=0.
  - Response: next cycle flush=1, redirect_pc=0x204; q_empty=1 (second entry discarded); pred_ready=0 for 1+HOLD_CYCLES=3 cycles; mispred_cnt=1.
- Target mispredict:
  - Stimulus: push {0x300, taken=1, 0x340}; resolve taken=1, target=0x380.
  - Response: flush=1, redirect_pc=0x380, upd_taken=1.
- Full/wrap:
  - Stimulus: push 4 entries; a 5th push with a simultaneous correct resolve.
  - Response: pred_ready=0, 5th push not accepted, count becomes 3.
  - Then push 6 more interleaved with correct resolves: FIFO order preserved across pointer wrap; every upd_taken matches its pushed branch.
- Error/saturation:
  - Stimulus: resolve on an empty queue.
  - Response: res_err=1, no upd_valid, branch_cnt unchanged.
  - With CNT_WIDTH=4: 17 correct resolves -> branch_cnt=15.
- Reset mid-recovery:
  - Stimulus: drive reset low during HOLD.
  - Response: flush=0, pred_ready=1 after release, counters 0, res_err=0.
